multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the single-ported RISC-V datapath: fetch, decode, execute, memory and writeback phases.
- Drives PC/IR write enables, memory requests, register-file write, ALU operation class and mux selects.
- Handles variable-latency memory with a timeout, traps on illegal opcodes, and counts retired instructions.
- Sits between the IR/ALU flags and the shared memory port; the ALU function-field decoder still consumes alu_op.

Parameters:
CNT_W, 32, width of the retired-instruction counter
MAX_WAIT, 255, max cycles to wait for mem_ready before trapping (1..2^16-1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
opcode  input  7  IR[6:0]; stable from DECODE until return to FETCH
funct3  input  3  IR[14:12]
alu_zero  input  1  ALU result == 0
alu_lt  input  1  ALU signed less-than
mem_ready  input  1  memory completes request this cycle
state  output  3  current state (debug)
pc_we  output  1  PC write enable
pc_sel  output  2  00 pc+4, 01 branch/jal target, 10 jalr target (ALU)
ir_we  output  1  IR load enable
mem_req  output  1  memory request
mem_we  output  1  memory write (store)
addr_sel  output  1  memory address: 0 PC, 1 ALU result
reg_we  output  1  register-file write enable
wb_sel  output  2  00 ALU, 01 memory data, 10 pc+4, 11 immediate (LUI)
alu_src  output  1  0 rs2, 1 immediate
alu_op  output  2  00 add, 01 branch/compare, 10 R-type, 11 I-arith
trap  output  1  sticky illegal-instruction/timeout flag
instret  output  CNT_W  retired-instruction count

Behaviour:
- Encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7. Registered state; outputs decoded combinationally from state, opcode, funct3, flags.
- Reset: while rst high at a clock edge, state<=IDLE, instret<=0, wait counter<=0, trap<=0. In IDLE all 1-bit outputs 0, selects 0. rst overrides any state, including TRAP and mid-memory wait; an outstanding request is abandoned.
- IDLE -> FETCH unconditionally next cycle.
- FETCH: mem_req=1, addr_sel=0. On mem_ready: ir_we=1 same cycle, -> DECODE. Else stay.
- DECODE: 1 cycle. Legal opcodes 0110011, 0000011, 0010011, 0100011, 1100011, 1100111, 0110111, 1101111 -> EXEC; else -> TRAP.
- EXEC by opcode:
  - R: alu_src=0, alu_op=10, -> WB.
  - I-arith: alu_src=1, alu_op=11, -> WB.
  - Load/store: alu_src=1, alu_op=00, -> MEM.
  - LUI: -> WB.
  - Branch: alu_src=0, alu_op=01. Taken: beq alu_zero, bne !alu_zero, blt alu_lt, bge !alu_lt. Other funct3 -> TRAP, no PC write. pc_we=1 always; pc_sel=01 if taken else 00. Retire, -> FETCH.
  - JAL: reg_we=1, wb_sel=10, pc_we=1, pc_sel=01. Retire, -> FETCH.
  - JALR: alu_src=1, alu_op=00, reg_we=1, wb_sel=10, pc_we=1, pc_sel=10. Retire, -> FETCH.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for store. Hold alu_src=1 and alu_op=00 so the address stays stable.
  - On mem_ready: store -> pc_we=1, pc_sel=00, retire, -> FETCH; load -> WB.
- WB: reg_we=1. wb_sel: 01 load, 11 LUI, else 00. Keep alu_src/alu_op as in EXEC. pc_we=1, pc_sel=00. Retire, -> FETCH.
- Retire: instret += 1 on that edge; wraps modulo 2^CNT_W.
- Wait counter: cleared on entry to FETCH/MEM and on mem_ready; increments each FETCH/MEM cycle without mem_ready. When it reaches MAX_WAIT without ready -> TRAP. mem_ready on the MAX_WAIT-th cycle wins over timeout.
- TRAP: trap=1, all other 1-bit outputs 0. Stays in TRAP until rst; instret frozen.
- reg_we, pc_we and mem_req are never asserted simultaneously with mem_we outside MEM/FETCH.

Test Plan:
- Reset mid-MEM wait (load, mem_ready low) -> next edge state=0, all enables 0, instret=0. Following cycle state=1, mem_req=1.
- Fetch mem_ready on 3rd cycle; ADD opcode 0110011 -> FETCH(3) DECODE EXEC WB. reg_we=1, wb_sel=00 only in WB; instret=1 after 6 cycles.
- LW with mem_ready immediate in both FETCH and MEM -> states 1,2,3,4,5,1; wb_sel=01 in WB. SW -> 1,2,3,4,1 with mem_we=1 only in MEM; instret=1.
- BNE funct3=001, alu_zero=0 -> pc_sel=01, pc_we=1 in EXEC. With alu_zero=1 -> pc_sel=00. funct3=010 -> state=7, trap=1, held until rst.
- JAL 1101111 -> EXEC shows reg_we=1, wb_sel=10, pc_sel=01. Opcode 0000000 -> DECODE->TRAP.
- MAX_WAIT=4, mem_ready never high in FETCH -> TRAP after 4 FETCH cycles. Repeat with mem_ready on 4th cycle -> DECODE, no trap.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for a single-ported RV32 datapath.
// Outputs are combinational from state/opcode/flags; memory waits on mem_ready with a bounded timeout.
module multicycle_ctrl #(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             alu_zero,
    input  logic             alu_lt,
    input  logic             mem_ready,
    output logic [2:0]       state,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             ir_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    typedef struct packed {
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       ir_we;
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam int WAIT_W = 16;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t           cur_state;
    state_t           nxt_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic             trap_q;
    ctrl_t            ctrl;

    logic is_r, is_load, is_imm, is_store, is_br, is_jalr, is_lui, is_jal;
    logic legal_op;
    logic br_legal;
    logic br_taken;
    logic timeout;
    logic retire;
    logic exec_alu_src;
    logic [1:0] exec_alu_op;

    assign is_r     = (opcode == OP_R);
    assign is_load  = (opcode == OP_LOAD);
    assign is_imm   = (opcode == OP_IMM);
    assign is_store = (opcode == OP_STORE);
    assign is_br    = (opcode == OP_BR);
    assign is_jalr  = (opcode == OP_JALR);
    assign is_lui   = (opcode == OP_LUI);
    assign is_jal   = (opcode == OP_JAL);
    assign legal_op = is_r | is_load | is_imm | is_store | is_br | is_jalr | is_lui | is_jal;

    always_comb begin
        br_legal = 1'b1;
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = alu_zero;
            3'b001:  br_taken = !alu_zero;
            3'b100:  br_taken = alu_lt;
            3'b101:  br_taken = !alu_lt;
            default: br_legal = 1'b0;
        endcase
    end

    // ALU configuration chosen in EXEC and held through MEM/WB so the result stays stable.
    always_comb begin
        exec_alu_src = 1'b0;
        exec_alu_op  = 2'b00;
        if (is_r) begin
            exec_alu_op = 2'b10;
        end else if (is_imm) begin
            exec_alu_src = 1'b1;
            exec_alu_op  = 2'b11;
        end else if (is_load || is_store || is_jalr) begin
            exec_alu_src = 1'b1;
        end else if (is_br) begin
            exec_alu_op = 2'b01;
        end
    end

    // The MAX_WAIT-th waiting cycle times out only if mem_ready is still low on it.
    assign timeout = !mem_ready && (wait_cnt == WAIT_LAST);

    assign retire = ((cur_state == S_EXEC) && (is_jal || is_jalr || (is_br && br_legal)))
                  || ((cur_state == S_MEM) && mem_ready && is_store)
                  || (cur_state == S_WB);

    always_comb begin
        wait_nxt = '0;
        if (((cur_state == S_FETCH) || (cur_state == S_MEM)) && !mem_ready)
            wait_nxt = wait_cnt + WAIT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= S_IDLE;
            wait_cnt  <= '0;
            trap_q    <= 1'b0;
            instret   <= '0;
        end else begin
            cur_state <= nxt_state;
            wait_cnt  <= wait_nxt;
            if (nxt_state == S_TRAP)
                trap_q <= 1'b1;
            if (retire)
                instret <= instret + CNT_W'(1);
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE:   nxt_state = S_FETCH;
            S_FETCH: begin
                if (mem_ready)    nxt_state = S_DECODE;
                else if (timeout) nxt_state = S_TRAP;
            end
            S_DECODE: nxt_state = legal_op ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (is_r || is_imm || is_lui)     nxt_state = S_WB;
                else if (is_load || is_store)     nxt_state = S_MEM;
                else if (is_br)                   nxt_state = br_legal ? S_FETCH : S_TRAP;
                else if (is_jal || is_jalr)       nxt_state = S_FETCH;
                else                              nxt_state = S_TRAP;
            end
            S_MEM: begin
                if (mem_ready)    nxt_state = is_store ? S_FETCH : S_WB;
                else if (timeout) nxt_state = S_TRAP;
            end
            S_WB:     nxt_state = S_FETCH;
            S_TRAP:   nxt_state = S_TRAP;
            default:  nxt_state = S_IDLE;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (cur_state)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.ir_we   = mem_ready;
            end
            S_EXEC: begin
                ctrl.alu_src = exec_alu_src;
                ctrl.alu_op  = exec_alu_op;
                if (is_br) begin
                    ctrl.pc_we  = br_legal;
                    ctrl.pc_sel = (br_legal && br_taken) ? 2'b01 : 2'b00;
                end else if (is_jal) begin
                    ctrl.reg_we = 1'b1;
                    ctrl.wb_sel = 2'b10;
                    ctrl.pc_we  = 1'b1;
                    ctrl.pc_sel = 2'b01;
                end else if (is_jalr) begin
                    ctrl.reg_we = 1'b1;
                    ctrl.wb_sel = 2'b10;
                    ctrl.pc_we  = 1'b1;
                    ctrl.pc_sel = 2'b10;
                end
            end
            S_MEM: begin
                ctrl.mem_req  = 1'b1;
                ctrl.addr_sel = 1'b1;
                ctrl.mem_we   = is_store;
                ctrl.alu_src  = 1'b1;
                ctrl.pc_we    = is_store && mem_ready;
            end
            S_WB: begin
                ctrl.reg_we  = 1'b1;
                ctrl.wb_sel  = is_load ? 2'b01 : (is_lui ? 2'b11 : 2'b00);
                ctrl.alu_src = exec_alu_src;
                ctrl.alu_op  = exec_alu_op;
                ctrl.pc_we   = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign state    = cur_state;
    assign pc_we    = ctrl.pc_we;
    assign pc_sel   = ctrl.pc_sel;
    assign ir_we    = ctrl.ir_we;
    assign mem_req  = ctrl.mem_req;
    assign mem_we   = ctrl.mem_we;
    assign addr_sel = ctrl.addr_sel;
    assign reg_we   = ctrl.reg_we;
    assign wb_sel   = ctrl.wb_sel;
    assign alu_src  = ctrl.alu_src;
    assign alu_op   = ctrl.alu_op;
    assign trap     = trap_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: sequences, branches, traps, timeouts and counter wrap.
module tb_multicycle_ctrl;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 4;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    logic             clk = 1'b0;
    logic             rst;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             alu_zero;
    logic             alu_lt;
    logic             mem_ready;
    logic [2:0]       state;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             ir_we;
    logic             mem_req;
    logic             mem_we;
    logic             addr_sel;
    logic             reg_we;
    logic [1:0]       wb_sel;
    logic             alu_src;
    logic [1:0]       alu_op;
    logic             trap;
    logic [CNT_W-1:0] instret;

    int n_chk = 0;
    int n_bad = 0;

    multicycle_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .mem_ready(mem_ready),
        .state(state), .pc_we(pc_we), .pc_sel(pc_sel), .ir_we(ir_we),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .reg_we(reg_we), .wb_sel(wb_sel), .alu_src(alu_src), .alu_op(alu_op),
        .trap(trap), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts in FETCH with mem_ready high; runs FETCH, DECODE, EXEC and checks the branch outputs.
    task automatic do_branch(input string tag, input logic [2:0] f3, input logic z,
                             input logic lt, input logic [1:0] exp_sel);
        opcode = OP_BR; funct3 = f3; alu_zero = z; alu_lt = lt; mem_ready = 1'b1;
        tick();
        tick();
        chk({tag, "_state"}, state, 3);
        chk({tag, "_pcwe"}, pc_we, 1);
        chk({tag, "_pcsel"}, pc_sel, exp_sel);
        chk({tag, "_aluop"}, {alu_src, alu_op}, 3'b001);
        tick();
        chk({tag, "_back"}, state, 1);
    endtask

    initial begin
        rst = 1'b1; opcode = '0; funct3 = '0; alu_zero = 1'b0; alu_lt = 1'b0; mem_ready = 1'b0;
        tick(); tick();
        chk("rst_state", state, 0);
        chk("rst_trap", trap, 0);
        chk("rst_instret", instret, 0);
        chk("rst_en", {pc_we, ir_we, mem_req, mem_we, reg_we, pc_sel, wb_sel, alu_op}, 0);

        // Load, then reset while MEM waits on mem_ready.
        rst = 1'b0; tick();
        chk("f1_state", state, 1);
        chk("f1_req", {mem_req, addr_sel, ir_we}, 3'b100);
        opcode = OP_LOAD; mem_ready = 1'b1; #1;
        chk("f1_irwe", ir_we, 1);
        tick(); mem_ready = 1'b0;
        chk("ld_dec", state, 2);
        tick();
        chk("ld_exec", state, 3);
        chk("ld_exec_alu", {alu_src, alu_op}, 3'b100);
        tick();
        chk("ld_mem", {state, mem_req, addr_sel, mem_we}, {3'd4, 3'b110});
        tick();
        chk("ld_wait", state, 4);
        rst = 1'b1; tick();
        chk("midrst_state", state, 0);
        chk("midrst_en", {pc_we, ir_we, mem_req, mem_we, reg_we}, 0);
        chk("midrst_instret", instret, 0);
        rst = 1'b0; tick();
        chk("postrst_fetch", {state, mem_req}, {3'd1, 1'b1});

        // ADD with fetch ready on the 3rd cycle.
        opcode = OP_R;
        tick(); chk("add_f2", state, 1);
        tick(); chk("add_f3", state, 1);
        mem_ready = 1'b1; #1;
        chk("add_irwe", ir_we, 1);
        tick(); mem_ready = 1'b0;
        chk("add_dec", {state, reg_we}, {3'd2, 1'b0});
        tick();
        chk("add_exec", {state, reg_we, alu_src, alu_op}, {3'd3, 4'b0010});
        tick();
        chk("add_wb", {state, reg_we, wb_sel, pc_we, pc_sel}, {3'd5, 6'b100100});
        chk("add_wb_alu", {alu_src, alu_op}, 3'b010);
        chk("add_wb_cnt", instret, 0);
        tick();
        chk("add_ret", {state, instret}, {3'd1, 4'd1});

        // LW with immediate readiness.
        opcode = OP_LOAD; mem_ready = 1'b1;
        tick(); chk("lw_s2", state, 2);
        tick(); chk("lw_s3", state, 3);
        tick(); chk("lw_s4", {state, mem_we, addr_sel}, {3'd4, 2'b01});
        tick(); chk("lw_wb", {state, wb_sel, reg_we}, {3'd5, 3'b011});
        tick(); chk("lw_ret", {state, instret}, {3'd1, 4'd2});

        // SW: write only in MEM, retires without WB.
        opcode = OP_STORE;
        tick(); chk("sw_s2", {state, mem_we}, {3'd2, 1'b0});
        tick(); chk("sw_s3", {state, mem_we}, {3'd3, 1'b0});
        tick(); chk("sw_mem", {state, mem_we, mem_req, pc_we, pc_sel, reg_we}, {3'd4, 6'b111000});
        tick(); chk("sw_ret", {state, mem_we, instret}, {3'd1, 1'b0, 4'd3});

        do_branch("bne_t", 3'b001, 1'b0, 1'b0, 2'b01);
        do_branch("bne_n", 3'b001, 1'b1, 1'b0, 2'b00);
        do_branch("blt_t", 3'b100, 1'b0, 1'b1, 2'b01);
        do_branch("bge_n", 3'b101, 1'b0, 1'b1, 2'b00);
        do_branch("beq_t", 3'b000, 1'b1, 1'b0, 2'b01);
        chk("br_cnt", instret, 8);

        opcode = OP_JAL;
        tick(); tick();
        chk("jal_exec", {state, reg_we, wb_sel, pc_we, pc_sel}, {3'd3, 6'b110101});
        tick(); chk("jal_ret", {state, instret}, {3'd1, 4'd9});

        opcode = OP_JALR;
        tick(); tick();
        chk("jalr_exec", {reg_we, wb_sel, pc_we, pc_sel, alu_src, alu_op}, 9'b110110100);
        tick(); chk("jalr_ret", instret, 10);

        opcode = OP_LUI;
        tick(); tick(); chk("lui_exec", {state, reg_we, pc_we}, {3'd3, 2'b00});
        tick(); chk("lui_wb", {state, wb_sel, reg_we}, {3'd5, 3'b111});
        tick(); chk("lui_ret", {state, instret}, {3'd1, 4'd11});

        // Fetch timeout after MAX_WAIT cycles; trap is sticky and freezes the counter.
        mem_ready = 1'b0;
        tick(); tick(); tick();
        chk("to_f4", {state, trap}, {3'd1, 1'b0});
        tick();
        chk("to_trap", {state, trap, mem_req}, {3'd7, 2'b10});
        mem_ready = 1'b1;
        tick(); tick();
        chk("to_hold", {state, trap, pc_we, ir_we, reg_we}, {3'd7, 4'b1000});
        chk("to_cnt", instret, 11);

        rst = 1'b1; tick();
        chk("trap_clr", {state, trap}, 0);
        rst = 1'b0; mem_ready = 1'b0; tick();
        tick(); tick(); tick();
        mem_ready = 1'b1; #1;
        chk("rdy4_irwe", ir_we, 1);
        tick();
        chk("rdy4_dec", {state, trap}, {3'd2, 1'b0});
        tick(); tick(); tick();
        chk("rdy4_ret", {state, instret}, {3'd1, 4'd1});

        // Branch with unsupported funct3 traps without a PC write or retirement.
        opcode = OP_BR; funct3 = 3'b010;
        tick(); tick();
        chk("badbr_exec", {state, pc_we}, {3'd3, 1'b0});
        tick(); chk("badbr_trap", {state, trap, instret}, {3'd7, 1'b1, 4'd1});
        tick(); chk("badbr_hold", {state, trap}, {3'd7, 1'b1});

        rst = 1'b1; tick(); rst = 1'b0; tick();
        opcode = 7'b0000000;
        tick(); chk("illop_dec", state, 2);
        tick(); chk("illop_trap", {state, trap, pc_we, reg_we}, {3'd7, 3'b100});

        // Memory-phase timeout on a load.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        opcode = OP_LOAD; mem_ready = 1'b1;
        tick(); mem_ready = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        chk("mto_m4", {state, mem_req, trap}, {3'd4, 2'b10});
        tick(); chk("mto_trap", {state, trap}, {3'd7, 1'b1});

        // Retire counter wraps modulo 2^CNT_W.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        opcode = OP_JAL; mem_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick(); tick(); tick();
        end
        chk("wrap_15", instret, 15);
        tick(); tick(); tick();
        chk("wrap_0", {state, instret}, {3'd1, 4'd0});

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
